// File: rtl/spi_master_engine_if.sv
// Request/response and SPI pin bundle for spi_master_engine.
// The master modport is the engine side; the slave modport is the requester/pin-model side.
interface spi_master_engine_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned DIV_WIDTH  = 8
);
    localparam int unsigned SS_SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

    logic                  start;
    logic                  ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [SS_SEL_W-1:0]   ss_sel;
    logic                  cpol;
    logic                  cpha;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  lsb_first;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  sck;
    logic                  mosi;
    logic                  miso;
    logic [NUM_SS-1:0]     ss_n;

    modport master (
        input  start, tx_data, ss_sel, cpol, cpha, clk_div, lsb_first, miso,
        output ready, rx_data, rx_valid, sck, mosi, ss_n
    );

    modport slave (
        output start, tx_data, ss_sel, cpol, cpha, clk_div, lsb_first, miso,
        input  ready, rx_data, rx_valid, sck, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_engine.sv
// SPI master serialiser: one word per request, run-time CPOL/CPHA/divider, captures MISO.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN (enables run-time LSB-first bit order).
module spi_master_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_engine_if.master bus
);
    localparam int unsigned SS_SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int unsigned EDGES    = 2 * DATA_WIDTH;
    localparam int unsigned EW       = $clog2(EDGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [EW-1:0]         edge_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-1:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  ready_q;
    logic                  sck_q;
    logic                  mosi_q;
    logic [NUM_SS-1:0]     ss_n_q;
    logic                  cpha_q;

    logic [DATA_WIDTH-1:0] src_c;
    logic                  bit_c;
    logic [DATA_WIDTH-1:0] shifted_c;
    logic [DATA_WIDTH-1:0] rx_next_c;
    logic [NUM_SS-1:0]     ss_dec_c;
    logic                  half_done_c;
    logic                  last_edge_c;
    logic                  sample_c;
    logic                  present_c;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q;
    logic lsb_c;
`else
    logic unused_lsb_first;
    assign unused_lsb_first = bus.lsb_first;
`endif

    // Bit presentation/assembly; in IDLE the first bit comes straight from the request word.
    always_comb begin
        src_c = (state_q == IDLE) ? bus.tx_data : tx_sh_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_c     = (state_q == IDLE) ? bus.lsb_first : lsb_q;
        bit_c     = lsb_c ? src_c[0] : src_c[DATA_WIDTH-1];
        shifted_c = lsb_c ? {1'b0, src_c[DATA_WIDTH-1:1]} : {src_c[DATA_WIDTH-2:0], 1'b0};
        rx_next_c = lsb_q ? {bus.miso, rx_sh_q[DATA_WIDTH-1:1]}
                          : {rx_sh_q[DATA_WIDTH-2:0], bus.miso};
`else
        bit_c     = src_c[DATA_WIDTH-1];
        shifted_c = {src_c[DATA_WIDTH-2:0], 1'b0};
        rx_next_c = {rx_sh_q[DATA_WIDTH-2:0], bus.miso};
`endif
    end

    // Slave-select decode; an out-of-range index leaves every line deasserted.
    always_comb begin
        ss_dec_c = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            ss_dec_c[i] = (bus.ss_sel != SS_SEL_W'(i));
        end
    end

    // Odd edges (edge_q even before the edge) are leading edges.
    always_comb begin
        half_done_c = (cnt_q == '0);
        last_edge_c = (edge_q == EW'(EDGES - 1));
        sample_c    = (edge_q[0] == cpha_q);
        present_c   = !sample_c && !last_edge_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            cpha_q     <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q  <= bus.cpol;
                    mosi_q <= 1'b0;
                    ss_n_q <= '1;
                    if (bus.start) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        cpha_q  <= bus.cpha;
                        div_q   <= bus.clk_div;
                        cnt_q   <= bus.clk_div;
                        edge_q  <= '0;
                        rx_sh_q <= '0;
                        ss_n_q  <= ss_dec_c;
`ifdef SPI_MASTER_LSB_FIRST_EN
                        lsb_q   <= bus.lsb_first;
`endif
                        if (!bus.cpha) begin
                            mosi_q  <= bit_c;
                            tx_sh_q <= shifted_c;
                        end else begin
                            tx_sh_q <= bus.tx_data;
                        end
                    end
                end
                SETUP, SHIFT: begin
                    if (!half_done_c) begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end else begin
                        cnt_q   <= div_q;
                        sck_q   <= ~sck_q;
                        edge_q  <= edge_q + EW'(1);
                        state_q <= last_edge_c ? HOLD : SHIFT;
                        if (sample_c) begin
                            rx_sh_q <= rx_next_c;
                        end
                        if (present_c) begin
                            mosi_q  <= bit_c;
                            tx_sh_q <= shifted_c;
                        end
                    end
                end
                HOLD: begin
                    if (!half_done_c) begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end else begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        ss_n_q     <= '1;
                        mosi_q     <= 1'b0;
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.sck      = sck_q;
    assign bus.mosi     = mosi_q;
    assign bus.ss_n     = ss_n_q;
endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: timing-formula reference model checked every cycle,
// a pin-level slave on MISO, directed scenarios plus randomized transfers.
module tb_spi_master_engine;
    localparam int DW   = 8;
    localparam int NSS  = 5;   // 3-bit select so out-of-range indices can be driven
    localparam int DIVW = 8;
    localparam int SSW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_engine_if #(.DATA_WIDTH(DW), .NUM_SS(NSS), .DIV_WIDTH(DIVW)) bus ();

    spi_master_engine #(.DATA_WIDTH(DW), .NUM_SS(NSS), .DIV_WIDTH(DIVW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state: one accepted transfer described by its accept cycle and settings.
    bit            have_t = 1'b0;
    int            t0 = 0;
    int            l_h = 1;
    logic [DW-1:0] l_tx = '0, l_word = '0, exp_rx = '0;
    logic [SSW-1:0] l_sel = '0;
    bit            l_cpol = 1'b0, l_cpha = 1'b0, l_lsb = 1'b0;
    bit            exp_idle_sck = 1'b0;
    bit            loop_mode = 1'b0, loop_next = 1'b0;
    logic [DW-1:0] word_next = '0;
    int            s_edges = 0;
    bit            s_prev = 1'b0, s_bit = 1'b0;

    assign bus.miso = loop_mode ? bus.mosi : s_bit;

    function automatic int done_off();
        return (2 * DW + 1) * l_h + 1;
    endfunction

    function automatic bit m_busy(input int c);
        int d = c - t0;
        return have_t && (d >= 1) && (d <= (2 * DW + 1) * l_h);
    endfunction

    function automatic bit obit(input logic [DW-1:0] w, input int idx);
        return l_lsb ? w[idx] : w[DW-1-idx];
    endfunction

    function automatic logic [NSS-1:0] dec(input logic [SSW-1:0] s);
        logic [NSS-1:0] r;
        for (int i = 0; i < NSS; i++) r[i] = (int'(s) != i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Model update from the inputs the DUT samples at this edge.
    always @(posedge clk) begin
        if (rst) begin
            have_t       = 1'b0;
            exp_rx       = '0;
            exp_idle_sck = 1'b0;
        end else begin
            if (!m_busy(cyc) && bus.start) begin
                t0      = cyc;
                have_t  = 1'b1;
                l_tx    = bus.tx_data;
                l_sel   = bus.ss_sel;
                l_cpol  = bus.cpol;
                l_cpha  = bus.cpha;
                l_h     = int'(bus.clk_div) + 1;
`ifdef SPI_MASTER_LSB_FIRST_EN
                l_lsb   = bus.lsb_first;
`else
                l_lsb   = 1'b0;
`endif
                loop_mode = loop_next;
                l_word  = loop_next ? bus.tx_data : word_next;
                s_edges = 0;
                s_prev  = bus.cpol;
            end else if (!m_busy(cyc)) begin
                exp_idle_sck = bus.cpol;
            end else begin
                exp_idle_sck = l_cpol;
            end
            if (have_t && (cyc + 1 - t0 == done_off())) exp_rx = l_word;
        end
        cyc++;
    end

    // Per-cycle compare, then the slave reacts to the SCK edges it has seen.
    always @(negedge clk) begin
        if (cyc > 0) begin
            int d, e, idx;
            logic [NSS-1:0] ess;
            bit es, em, ev, er;
            d = cyc - t0;
            if (m_busy(cyc)) begin
                e = (d - 1) / l_h;
                if (e > 2 * DW) e = 2 * DW;
                er  = 1'b0;
                ess = dec(l_sel);
                es  = l_cpol ^ e[0];
                if (!l_cpha) em = obit(l_tx, (e / 2 > DW - 1) ? DW - 1 : e / 2);
                else         em = (e == 0) ? 1'b0 : obit(l_tx, (e - 1) / 2);
                ev  = 1'b0;
            end else begin
                er  = 1'b1;
                ess = '1;
                es  = exp_idle_sck;
                em  = 1'b0;
                ev  = have_t && (d == done_off());
            end
            chk("ready",    bus.ready,    er);
            chk("ss_n",     bus.ss_n,     ess);
            chk("sck",      bus.sck,      es);
            chk("mosi",     bus.mosi,     em);
            chk("rx_valid", bus.rx_valid, ev);
            chk("rx_data",  bus.rx_data,  exp_rx);

            if (m_busy(cyc)) begin
                if (bus.sck !== s_prev) begin
                    s_edges++;
                    s_prev = bus.sck;
                end
                if (l_cpha) idx = (s_edges == 0) ? 0 : (s_edges - 1) / 2;
                else        idx = (s_edges / 2 > DW - 1) ? DW - 1 : s_edges / 2;
                s_bit = obit(l_word, idx);
            end
        end
    end

    task automatic xfer(input logic [DW-1:0] tx, input int sel, input bit cp, input bit ph,
                        input int div, input bit lsb, input bit lp, input logic [DW-1:0] w,
                        input bit noise, output int t_acc, output int t_done,
                        output logic [DW-1:0] rx, output logic [NSS-1:0] ss1, output bit mosi1);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        loop_next     = lp;
        word_next     = w;
        bus.tx_data   = tx;
        bus.ss_sel    = SSW'(sel);
        bus.cpol      = cp;
        bus.cpha      = ph;
        bus.clk_div   = DIVW'(div);
        bus.lsb_first = lsb;
        bus.start     = 1'b1;
        t_acc = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
        ss1   = bus.ss_n;
        mosi1 = bus.mosi;
        bus.tx_data   = DW'($urandom);
        bus.ss_sel    = SSW'($urandom);
        bus.cpha      = 1'($urandom);
        bus.clk_div   = DIVW'($urandom);
        bus.lsb_first = 1'($urandom);
        n = 0;
        while (bus.rx_valid !== 1'b1 && n < 5000) begin
            if (noise) bus.start = 1'($urandom);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("done_in_budget", 32'(n < 5000), 32'd1);
        t_done = cyc;
        rx     = bus.rx_data;
    endtask

    initial begin
        int ta, td, cnt, high, pulses;
        bit seen, m1, drop;
        logic [DW-1:0] rx;
        logic [NSS-1:0] s1;

        bus.start = 1'b0; bus.tx_data = '0; bus.ss_sel = '0; bus.cpol = 1'b0;
        bus.cpha = 1'b0; bus.clk_div = '0; bus.lsb_first = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", bus.ready, 1'b1);
        chk("reset_ss_n", bus.ss_n, 5'b11111);

        // Mode 0, divider 1, loopback.
        xfer(8'hA5, 2, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h00, 1'b0, ta, td, rx, s1, m1);
        chk("m0_ss_n_first", s1, 5'b11011);
        chk("m0_latency", 32'(td - ta), 32'd35);
        chk("m0_rx", rx, 8'hA5);

        // Mode 3, divider 0, slave returns 0xC3.
        xfer(8'h3C, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'hC3, 1'b0, ta, td, rx, s1, m1);
        chk("m3_latency", 32'(td - ta), 32'd18);
        chk("m3_rx", rx, 8'hC3);
        chk("m3_sck_idle", bus.sck, 1'b1);

        // Bit-order request with a single set LSB.
        xfer(8'h01, 1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h00, 1'b0, ta, td, rx, s1, m1);
`ifdef SPI_MASTER_LSB_FIRST_EN
        chk("lsb_first_bit", m1, 1'b1);
`else
        chk("lsb_first_bit", m1, 1'b0);
`endif
        chk("lsb_rx", rx, 8'h01);

        // Back-to-back: start held high across two words.
        repeat (2) @(negedge clk);
        loop_next = 1'b1;
        bus.tx_data = 8'h11; bus.ss_sel = 3'd1; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.clk_div = 8'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'h22;
        high = 0; pulses = 0; seen = 1'b0; drop = 1'b0; rx = '0;
        for (int n = 0; n < 200; n++) begin
            if (drop) bus.start = 1'b0;
            if (bus.rx_valid === 1'b1) begin
                pulses++;
                drop = 1'b1;
                if (pulses == 2) begin
                    rx = bus.rx_data;
                    break;
                end
            end
            if (seen && bus.ss_n === 5'b11111) high++;
            if (bus.ss_n !== 5'b11111) seen = 1'b1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_gap", 32'(high), 32'd1);
        chk("b2b_rx2", rx, 8'h22);

        // Reset at SCK edge 5.
        repeat (2) @(negedge clk);
        loop_next = 1'b1;
        bus.tx_data = 8'h5A; bus.ss_sel = 3'd0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.clk_div = 8'd1; bus.start = 1'b1;
        ta = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < ta + 11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ss_n", bus.ss_n, 5'b11111);
        chk("rst_sck", bus.sck, 1'b0);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) cnt++;
        end
        chk("rst_no_pulse", 32'(cnt), 32'd0);

        // Out-of-range select, divider 2.
        xfer(8'h96, 5, 1'b0, 1'b1, 2, 1'b0, 1'b0, 8'h69, 1'b0, ta, td, rx, s1, m1);
        chk("oor_ss_n", s1, 5'b11111);
        chk("oor_latency", 32'(td - ta), 32'd52);
        chk("oor_rx", rx, 8'h69);

        // Randomized transfers with start noise while busy.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.cpol = 1'($urandom);
                @(negedge clk);
            end
            xfer(DW'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), DW'($urandom),
                 1'b1, ta, td, rx, s1, m1);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
